// File: rtl/point_collector.sv
// Per-frame collision checker for the five collectible squares of the active level.
// Owns the visible point mask, the per-level collected count and the saturating score.
module point_collector #(
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 16,
    parameter int POINT_W  = 20,
    parameter int POINT_H  = 20,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         lvl,
    input  logic               level_start,
    input  logic               frame_tick,
    input  logic [10:0]        player_x,
    input  logic [10:0]        player_y,
    output logic [4:0]         point_enable,
    output logic [2:0]         collected,
    output logic [SCORE_W-1:0] score,
    output logic               level_done,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [4:0]         point_enable_r, point_enable_nxt_s;
    logic [2:0]         collected_r, collected_nxt_s;
    logic [SCORE_W-1:0] score_r, score_nxt_s;
    logic               level_done_r, level_done_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [4:0]         hit_r, hit_nxt_s;
    logic [1:0]         lvl_q_r, lvl_q_nxt_s;

    logic               lvl_valid_s;
    logic [4:0]         overlap_s;
    logic [4:0]         mask_commit_s;
    logic [2:0]         cnt_s;
    logic [SCORE_W:0]   score_sum_s;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 5; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    function automatic logic [11:0] point_x(input logic [1:0] l, input int i);
        logic [11:0] x;
        x = 12'd0;
        if (l == 2'd1) begin
            case (i)
                0:       x = 12'd265;
                1:       x = 12'd515;
                2:       x = 12'd235;
                3:       x = 12'd310;
                4:       x = 12'd400;
                default: x = 12'd0;
            endcase
        end else begin
            x = 12'd0;
        end
        return x;
    endfunction

    function automatic logic [11:0] point_y(input logic [1:0] l, input int i);
        logic [11:0] y;
        y = 12'd0;
        if (l == 2'd1) begin
            case (i)
                0:       y = 12'd220;
                1:       y = 12'd120;
                2:       y = 12'd500;
                3:       y = 12'd460;
                4:       y = 12'd550;
                default: y = 12'd0;
            endcase
        end else begin
            y = 12'd0;
        end
        return y;
    endfunction

    // Strict box overlap; 12-bit operands so the right/bottom edges never wrap.
    function automatic logic box_hit(input logic [11:0] px, input logic [11:0] py,
                                     input logic [11:0] xi, input logic [11:0] yi);
        return (px < xi + 12'(POINT_W)) && (px + 12'(PLAYER_W) > xi) &&
               (py < yi + 12'(POINT_H)) && (py + 12'(PLAYER_H) > yi);
    endfunction

    assign lvl_valid_s   = level_start && (lvl != 3'd0) && (lvl <= 3'd3);
    assign mask_commit_s = point_enable_r & ~hit_r;
    // Only still-present bits are counted, so a back-to-back frame cannot double count.
    assign cnt_s         = popcount5(point_enable_r & hit_r);
    assign score_sum_s   = {1'b0, score_r} + {{(SCORE_W-2){1'b0}}, cnt_s};

    // Overlap of the player box against every point of the latched level.
    always_comb begin
        overlap_s = 5'd0;
        for (int i = 0; i < 5; i++) begin
            overlap_s[i] = box_hit({1'b0, player_x}, {1'b0, player_y},
                                   point_x(lvl_q_r, i), point_y(lvl_q_r, i));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (lvl_valid_s) state_nxt_s = PLAY;
                else             state_nxt_s = IDLE;
            end
            PLAY: begin
                if (lvl_valid_s)                 state_nxt_s = PLAY;
                else if (mask_commit_s == 5'd0)  state_nxt_s = DONE;
                else                             state_nxt_s = PLAY;
            end
            DONE: begin
                if (lvl_valid_s) state_nxt_s = PLAY;
                else             state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the datapath/output registers.
    always_comb begin
        point_enable_nxt_s = point_enable_r;
        collected_nxt_s    = collected_r;
        score_nxt_s        = score_r;
        hit_nxt_s          = 5'd0;
        lvl_q_nxt_s        = lvl_q_r;
        level_done_nxt_s   = 1'b0;
        busy_nxt_s         = (state_nxt_s == PLAY);
        if (lvl_valid_s) begin
            lvl_q_nxt_s        = lvl[1:0];
            point_enable_nxt_s = 5'b11111;
            collected_nxt_s    = 3'd0;
        end else if (state_r == PLAY) begin
            point_enable_nxt_s = mask_commit_s;
            collected_nxt_s    = collected_r + cnt_s;
            score_nxt_s        = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
            level_done_nxt_s   = (mask_commit_s == 5'd0);
            if (frame_tick && (mask_commit_s != 5'd0)) begin
                hit_nxt_s = overlap_s & point_enable_r;
            end else begin
                hit_nxt_s = 5'd0;
            end
        end else begin
            hit_nxt_s = 5'd0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            point_enable_r <= 5'd0;
            collected_r    <= 3'd0;
            score_r        <= {SCORE_W{1'b0}};
            level_done_r   <= 1'b0;
            busy_r         <= 1'b0;
            hit_r          <= 5'd0;
            lvl_q_r        <= 2'd0;
        end else begin
            point_enable_r <= point_enable_nxt_s;
            collected_r    <= collected_nxt_s;
            score_r        <= score_nxt_s;
            level_done_r   <= level_done_nxt_s;
            busy_r         <= busy_nxt_s;
            hit_r          <= hit_nxt_s;
            lvl_q_r        <= lvl_q_nxt_s;
        end
    end

    assign point_enable = point_enable_r;
    assign collected    = collected_r;
    assign score        = score_r;
    assign level_done   = level_done_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_point_collector.sv
// Directed plus randomized bench for point_collector against a frame-level reference model.
module tb_point_collector;

    localparam int PW = 16, PH = 16, QW = 20, QH = 20, SW = 8;

    logic          clk, rst, level_start, frame_tick;
    logic [2:0]    lvl;
    logic [10:0]   player_x, player_y;
    logic [4:0]    point_enable;
    logic [2:0]    collected;
    logic [SW-1:0] score;
    logic          level_done, busy;

    point_collector #(.PLAYER_W(PW), .PLAYER_H(PH), .POINT_W(QW), .POINT_H(QH), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .lvl(lvl), .level_start(level_start), .frame_tick(frame_tick),
        .player_x(player_x), .player_y(player_y), .point_enable(point_enable),
        .collected(collected), .score(score), .level_done(level_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int tab_x[5] = '{265, 515, 235, 310, 400};
    int tab_y[5] = '{220, 120, 500, 460, 550};

    // Reference model state: 0 idle, 1 playing, 2 level cleared.
    int m_st, m_lvl, m_mask, m_coll, m_score, m_pend, m_done;

    function automatic bit m_overlap(int l, int i, int x, int y);
        int xi, yi;
        xi = (l == 1) ? tab_x[i] : 0;
        yi = (l == 1) ? tab_y[i] : 0;
        return (x < xi + QW) && (x + PW > xi) && (y < yi + QH) && (y + PH > yi);
    endfunction

    function automatic int bits_set(int v);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) n += (v >> i) & 1;
        return n;
    endfunction

    task automatic m_reset();
        m_st = 0; m_lvl = 0; m_mask = 0; m_coll = 0; m_score = 0; m_pend = 0; m_done = 0;
    endtask

    // Frame-level model: hits found on a tick are removed one cycle later.
    task automatic m_step(int ls, int lv, int ft, int x, int y);
        int newpend, n;
        m_done = 0;
        if (ls != 0 && lv >= 1 && lv <= 3) begin
            m_lvl = lv; m_mask = 31; m_coll = 0; m_pend = 0; m_st = 1;
        end else if (m_st == 1) begin
            newpend = 0;
            if (ft != 0) begin
                for (int i = 0; i < 5; i++)
                    if (m_overlap(m_lvl, i, x, y) && ((m_mask >> i) & 1) == 1) newpend |= (1 << i);
            end
            n = bits_set(m_pend & m_mask);
            m_mask = m_mask & ~m_pend;
            m_coll += n;
            m_score = (m_score + n > 255) ? 255 : m_score + n;
            if (m_mask == 0) begin
                m_st = 2; m_done = 1; m_pend = 0;
            end else begin
                m_pend = newpend;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("point_enable", {27'd0, point_enable}, m_mask);
        chk("collected", {29'd0, collected}, m_coll);
        chk("score", {24'd0, score}, m_score);
        chk("level_done", {31'd0, level_done}, m_done);
        chk("busy", {31'd0, busy}, (m_st == 1) ? 1 : 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_point_enable", {27'd0, point_enable}, 32'd0);
        chk("rst_collected", {29'd0, collected}, 32'd0);
        chk("rst_score", {24'd0, score}, 32'd0);
        chk("rst_level_done", {31'd0, level_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic cyc(int ls, int lv, int ft, int x, int y);
        level_start = ls[0];
        lvl         = lv[2:0];
        frame_tick  = ft[0];
        player_x    = x[10:0];
        player_y    = y[10:0];
        m_step(ls, lv, ft, x, y);
        @(posedge clk);
        #1;
        level_start = 1'b0;
        frame_tick  = 1'b0;
        check_all();
    endtask

    initial begin
        int guard, k, x, y, ls, lv, ft;
        level_start = 1'b0; frame_tick = 1'b0; lvl = 3'd0;
        player_x = 11'd0; player_y = 11'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        m_reset();
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        // Invalid level ignored, then arm level 1.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("start_mask", {27'd0, point_enable}, 32'd31);

        // Single hit and the exact-boundary miss.
        cyc(0, 0, 1, 250, 210);
        cyc(0, 0, 0, 0, 0);
        chk("first_hit_mask", {27'd0, point_enable}, 32'd30);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 249, 210);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("boundary_miss", {27'd0, point_enable}, 32'd31);

        // Visit all five points in turn; level_done must come on the last only.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, tab_x[i] - 2, tab_y[i] - 2);
            cyc(0, 0, 0, 0, 0);
        end
        chk("all_cleared_done", {31'd0, level_done}, 32'd1);
        cyc(0, 0, 1, tab_x[0], tab_y[0]);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Level 2: every point at origin, one frame clears them all.
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("lvl2_collected", {29'd0, collected}, 32'd5);
        cyc(0, 0, 0, 0, 0);

        // Restart on the same edge as a pending commit discards the hit.
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 250, 210);
        cyc(1, 1, 0, 0, 0);
        chk("restart_mask", {27'd0, point_enable}, 32'd31);

        // Back-to-back ticks on the same point count it once.
        cyc(0, 0, 1, 250, 210);
        cyc(0, 0, 1, 250, 210);
        cyc(0, 0, 0, 0, 0);
        chk("b2b_collected", {29'd0, collected}, 32'd1);

        // Randomized play around the level-1 points.
        for (int n = 0; n < 400; n++) begin
            ls = ($urandom_range(0, 39) == 0) ? 1 : 0;
            lv = $urandom_range(1, 3);
            ft = (ls == 0 && $urandom_range(0, 2) == 0) ? 1 : 0;
            if ($urandom_range(0, 5) == 0) begin
                x = $urandom_range(0, 40);
                y = $urandom_range(0, 40);
            end else begin
                k = $urandom_range(0, 4);
                x = tab_x[k] + $urandom_range(0, 50) - 25;
                y = tab_y[k] + $urandom_range(0, 50) - 25;
            end
            cyc(ls, lv, ft, x, y);
        end

        // Drive the score to saturation.
        guard = 0;
        while (m_score < 250 && guard < 100) begin
            cyc(1, 2, 0, 0, 0);
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
            guard++;
        end
        while (m_score < 254 && guard < 200) begin
            cyc(1, 1, 0, 0, 0);
            cyc(0, 0, 1, 250, 210);
            cyc(0, 0, 0, 0, 0);
            guard++;
        end
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("score_saturated", {24'd0, score}, 32'd255);

        // Asynchronous reset in the middle of a level.
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 1, 250, 210);
        cyc(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
